// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: brings asynchronous off-chip inputs (buttons, switches)
// into the core clock domain. Each bit is synchronized, debounced by a
// counter FSM and edge-detected into a sticky pending flag. A masked,
// per-bit acknowledged interrupt summarizes the pending events.
`timescale 1ns/1ps

// One input bit: synchronizer chain, debounce FSM, edge detect, pending flag.
module gpio_in_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  input  logic rise_en_i,
  input  logic fall_en_i,
  input  logic ack_i,
  output logic level_o,
  output logic pending_o
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  // cnt holds the number of mismatching edges already seen; the edge that
  // would bring it to DEBOUNCE_CYCLES commits the new level instead.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_STABLE, ST_COUNTING} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pending_q, pending_d;
  logic                   rise, fall, set;

  // Plain flop chain; nothing sits between stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Debounce state, counter, level and pending registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_STABLE;
      cnt_q     <= '0;
      level_q   <= RESET_LEVEL;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pending_q <= pending_d;
    end
  end

  // Next state: count consecutive mismatches, any match restarts the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sync != level_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            level_d = sync;
          end else begin
            state_d = ST_COUNTING;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_COUNTING: begin
        if (sync == level_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          level_d = sync;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Edge strobes on the commit edge; a new event beats a same-edge ack.
  always_comb begin
    rise      = (level_d != level_q) &  level_d;
    fall      = (level_d != level_q) & ~level_d;
    set       = (rise & rise_en_i) | (fall & fall_en_i);
    pending_d = set ? 1'b1 : (ack_i ? 1'b0 : pending_q);
  end

  assign level_o   = level_q;
  assign pending_o = pending_q;
endmodule

// Top: one independent debounce lane per input bit plus the masked irq.
module gpio_in_debounce #(
  parameter int unsigned       WIDTH           = 4,
  parameter int unsigned       DEBOUNCE_CYCLES = 1000,
  parameter int unsigned       SYNC_STAGES     = 2,
  parameter logic [WIDTH-1:0]  RESET_LEVEL     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] ack,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] pending,
  output logic             irq
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_in_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .RESET_LEVEL     (RESET_LEVEL[i])
    ) u_bit (
      .clk       (clk),
      .reset_n   (reset_n),
      .pin_i     (pins_in[i]),
      .rise_en_i (rise_en[i]),
      .fall_en_i (fall_en[i]),
      .ack_i     (ack[i]),
      .level_o   (level_out[i]),
      .pending_o (pending[i])
    );
  end

  // Only registered pending reaches irq; the mask acts combinationally.
  assign irq = |(pending & irq_mask);
endmodule

// File: tb/tb_gpio_in_debounce.sv
// Bench for gpio_in_debounce: directed scenarios then random pin activity,
// checked every cycle against a run-length reference model via a scoreboard.
`timescale 1ns/1ps

module tb_gpio_in_debounce;
  localparam int W  = 4;
  localparam int DC = 8;
  localparam int SS = 2;
  localparam logic [W-1:0] RL = '0;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] pins_in, rise_en, fall_en, irq_mask, ack;
  logic [W-1:0] level_out, pending;
  logic         irq;

  always #5 clk = ~clk;

  gpio_in_debounce #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS), .RESET_LEVEL(RL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pins_in(pins_in), .rise_en(rise_en),
    .fall_en(fall_en), .irq_mask(irq_mask), .ack(ack),
    .level_out(level_out), .pending(pending), .irq(irq)
  );

  typedef struct packed {
    logic [W-1:0] lvl;
    logic [W-1:0] pend;
    logic         irq;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
  endtask

  // Reference model: pins delayed SS edges, then a level flips once DC
  // consecutive samples disagree with it.
  logic [W-1:0] m_dq[$];
  logic [W-1:0] m_lvl, m_pend;
  int           m_run[W];

  task automatic m_reset();
    m_dq = {};
    for (int k = 0; k < SS; k++) m_dq.push_back(RL);
    m_lvl  = RL;
    m_pend = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  task automatic m_step();
    logic [W-1:0] s, nl, ev;
    exp_t e;
    if (!reset_n) begin
      m_reset();
    end else begin
      s = m_dq.pop_front();
      m_dq.push_back(pins_in);
      nl = m_lvl;
      ev = '0;
      for (int i = 0; i < W; i++) begin
        if (s[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin
            nl[i]    = s[i];
            ev[i]    = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_pend = (ev & ((nl & rise_en) | (~nl & fall_en))) | (m_pend & ~ack);
      m_lvl  = nl;
    end
    e.lvl  = m_lvl;
    e.pend = m_pend;
    e.irq  = |(m_pend & irq_mask);
    sb.push_back(e);
  endtask

  // Inputs are final for the next posedge: predict it, then move to negedge.
  task automatic cycle();
    m_step();
    @(negedge clk);
  endtask

  // Monitor: compares each post-edge DUT state with the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_level_out", level_out, e.lvl);
        chk("sb_pending", pending, e.pend);
        chk("sb_irq", irq, e.irq);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    reset_n = 1'b0; pins_in = '1; rise_en = '1; fall_en = '0;
    irq_mask = '1; ack = '0;
    m_reset();

    // Reset hold with pins high, then release and measure latency.
    repeat (5) cycle();
    #1;
    chk("rst_level", level_out, 0);
    chk("rst_pending", pending, 0);
    chk("rst_irq", irq, 0);
    reset_n = 1'b1;
    first = 0;
    for (int k = 1; k <= 14; k++) begin
      cycle();
      if (first == 0 && level_out == 4'hF) first = k;
    end
    chk("rst_release_latency", first, 10);
    chk("rst_release_pending", pending, 4'hF);
    chk("rst_release_irq", irq, 1);

    // Clean rise on bit 0, then ack.
    pins_in = '0; rise_en = 4'b0001; ack = '1;
    repeat (14) cycle();
    ack = '0; irq_mask = 4'b0001;
    pins_in[0] = 1'b1;
    first = 0;
    for (int k = 1; k <= 14; k++) begin
      cycle();
      if (first == 0 && level_out[0]) first = k;
    end
    chk("rise0_latency", first, 10);
    chk("rise0_irq", irq, 1);
    ack[0] = 1'b1;
    cycle();
    ack = '0;
    chk("ack0_pending", pending[0], 0);
    chk("ack0_irq", irq, 0);

    // Glitch filtering on bit 1: 7 cycles rejected, 8 accepted.
    rise_en = 4'b0010;
    pins_in[1] = 1'b1; repeat (7) cycle();
    pins_in[1] = 1'b0; repeat (12) cycle();
    chk("glitch7_level", level_out[1], 0);
    chk("glitch7_pending", pending[1], 0);
    pins_in[1] = 1'b1; repeat (8) cycle();
    pins_in[1] = 1'b0; repeat (2) cycle();
    chk("pulse8_rise", level_out[1], 1);
    chk("pulse8_pending", pending[1], 1);
    repeat (7) cycle();
    chk("pulse8_hold", level_out[1], 1);
    cycle();
    chk("pulse8_fall", level_out[1], 0);

    // Set/ack collision on bit 0.
    ack = '1; cycle(); ack = '0;
    rise_en = 4'b0001;
    pins_in[0] = 1'b0; repeat (12) cycle();
    pins_in[0] = 1'b1; repeat (9) cycle();
    ack[0] = 1'b1; cycle(); ack = '0;
    chk("collision_level", level_out[0], 1);
    chk("collision_pending", pending[0], 1);

    // Reset mid-count on bit 2 (cnt = 5), then full restart.
    rise_en = 4'b0100;
    pins_in = 4'b0100; repeat (7) cycle();
    chk("pre_rst_level", level_out, 4'b0001);
    reset_n = 1'b0;
    #1;
    chk("midrst_level", level_out, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_irq", irq, 0);
    repeat (2) cycle();
    reset_n = 1'b1;
    first = 0;
    for (int k = 1; k <= 14; k++) begin
      cycle();
      if (first == 0 && level_out[2]) first = k;
    end
    chk("midrst_latency", first, 10);

    // Enable gating and lane independence on bits 2 and 3.
    ack = '1; rise_en = '0; fall_en = 4'b1000; irq_mask = '0; pins_in = '0;
    repeat (12) cycle();
    ack = '0;
    pins_in[3:2] = 2'b11; repeat (12) cycle();
    chk("gate_rise_level", level_out[3:2], 2'b11);
    chk("gate_rise_pending", pending, 0);
    pins_in[3:2] = 2'b00; repeat (12) cycle();
    chk("gate_fall_level", level_out[3:2], 2'b00);
    chk("gate_fall_pending", pending, 4'b1000);
    chk("gate_masked_irq", irq, 0);
    irq_mask = 4'b1000;
    #1;
    chk("gate_unmask_irq", irq, 1);
    cycle();

    // Random pin activity with random enables, masks, acks, rare resets.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 9) == 0) pins_in[i] = ~pins_in[i];
      if ($urandom_range(0, 49) == 0) rise_en  = W'($urandom);
      if ($urandom_range(0, 49) == 0) fall_en  = W'($urandom);
      if ($urandom_range(0, 19) == 0) irq_mask = W'($urandom);
      ack     = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      reset_n = ($urandom_range(0, 499) != 0);
      cycle();
    end
    reset_n = 1'b1; ack = '0;

    // Drain the scoreboard within a bounded number of edges.
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
